// File: rtl/rv32i_redirect_ctrl.sv
// rv32i_redirect_ctrl: front-end redirect sequencer
// Arbitrates exception/irq/mispredict, flushes, drains PUs, redirects fetch.
module rv32i_redirect_ctrl #(
   parameter int NUM_PUS       = 4,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_except_vld,
   input  logic [31:0]        i_except_pc,
   input  logic [3:0]         i_except_cause,
   input  logic               i_irq,
   input  logic [31:0]        i_irq_pc,
   input  logic               i_mispred_vld,
   input  logic [31:0]        i_mispred_pc,
   input  logic [31:0]        i_mtvec,
   input  logic [NUM_PUS-1:0] i_pu_vld,
   input  logic [NUM_PUS-1:0] i_pu_rdy,
   input  logic               i_fetch_rdy,
   output logic               o_stall,
   output logic               o_flush,
   output logic               o_csr_we,
   output logic [31:0]        o_mepc,
   output logic [31:0]        o_mcause,
   output logic               o_redirect_vld,
   output logic [31:0]        o_redirect_pc,
   output logic               o_drain_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_DRAIN,
      S_REDIR
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_trap;
   logic        r_csr_we;
   logic        r_drain_err;
   logic [31:0] r_pc;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;

   logic        w_req;
   logic        w_flushed;
   logic [7:0]  w_cnt_inc;
   logic        w_timeout;
   logic [31:0] w_vec;

   assign w_req     = i_except_vld | i_irq | i_mispred_vld;
   assign w_flushed = ~|i_pu_vld & &i_pu_rdy;
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_timeout = ~w_flushed & (w_cnt_inc == 8'(DRAIN_TIMEOUT));
   assign w_vec     = {i_mtvec[31:2], 2'b00};

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_req) w_next = S_FLUSH;
         S_FLUSH: w_next = S_DRAIN;
         S_DRAIN: if (w_flushed | w_timeout) w_next = S_REDIR;
         S_REDIR: if (i_fetch_rdy) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // capture the winning request; mispredict leaves trap CSR data untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_mepc   <= '0;
         r_mcause <= '0;
         r_trap   <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (i_except_vld) begin
            r_pc     <= w_vec;
            r_mepc   <= i_except_pc;
            r_mcause <= {28'b0, i_except_cause};
            r_trap   <= 1'b1;
         end else if (i_irq) begin
            r_pc     <= w_vec;
            r_mepc   <= i_irq_pc;
            r_mcause <= {1'b1, 27'b0, 4'd11};
            r_trap   <= 1'b1;
         end else if (i_mispred_vld) begin
            r_pc     <= i_mispred_pc;
            r_trap   <= 1'b0;
         end
      end
   end

   // drain cycle counter, cleared on flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cnt <= '0;
      else if (r_state == S_FLUSH) r_cnt <= '0;
      else if (r_state == S_DRAIN && !w_flushed) r_cnt <= w_cnt_inc;
   end

   // CSR write strobe for the first redirect cycle, sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csr_we    <= 1'b0;
         r_drain_err <= 1'b0;
      end else begin
         r_csr_we <= (r_state == S_DRAIN) & (w_next == S_REDIR) & r_trap;
         if (r_state == S_DRAIN && w_timeout) r_drain_err <= 1'b1;
      end
   end

   assign o_stall        = (r_state != S_IDLE);
   assign o_flush        = (r_state == S_FLUSH);
   assign o_redirect_vld = (r_state == S_REDIR);
   assign o_redirect_pc  = r_pc;
   assign o_csr_we       = r_csr_we;
   assign o_mepc         = r_mepc;
   assign o_mcause       = r_mcause;
   assign o_drain_err    = r_drain_err;

endmodule

// File: tb/tb_rv32i_redirect_ctrl.sv
// tb_rv32i_redirect_ctrl: directed plus randomized sequences
// Expected timeline derived per transaction from request/drain/fetch params.
module tb_rv32i_redirect_ctrl;

   localparam int NP = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_except_vld = 1'b0;
   logic [31:0]   i_except_pc = '0;
   logic [3:0]    i_except_cause = '0;
   logic          i_irq = 1'b0;
   logic [31:0]   i_irq_pc = '0;
   logic          i_mispred_vld = 1'b0;
   logic [31:0]   i_mispred_pc = '0;
   logic [31:0]   i_mtvec = '0;
   logic [NP-1:0] i_pu_vld = '0;
   logic [NP-1:0] i_pu_rdy = '1;
   logic          i_fetch_rdy = 1'b0;
   logic          o_stall;
   logic          o_flush;
   logic          o_csr_we;
   logic [31:0]   o_mepc;
   logic [31:0]   o_mcause;
   logic          o_redirect_vld;
   logic [31:0]   o_redirect_pc;
   logic          o_drain_err;

   int vectors = 0;
   int errs = 0;
   bit err_exp = 1'b0;

   rv32i_redirect_ctrl #(.NUM_PUS(NP), .DRAIN_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_except_vld(i_except_vld), .i_except_pc(i_except_pc),
      .i_except_cause(i_except_cause), .i_irq(i_irq),
      .i_irq_pc(i_irq_pc), .i_mispred_vld(i_mispred_vld),
      .i_mispred_pc(i_mispred_pc), .i_mtvec(i_mtvec),
      .i_pu_vld(i_pu_vld), .i_pu_rdy(i_pu_rdy),
      .i_fetch_rdy(i_fetch_rdy), .o_stall(o_stall),
      .o_flush(o_flush), .o_csr_we(o_csr_we),
      .o_mepc(o_mepc), .o_mcause(o_mcause),
      .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
      .o_drain_err(o_drain_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_pu(input bit busy);
      if (!busy) begin
         i_pu_vld = '0;
         i_pu_rdy = '1;
      end else if ($urandom_range(0, 1) == 1) begin
         i_pu_vld = NP'($urandom_range(1, 15));
         i_pu_rdy = '1;
      end else begin
         i_pu_vld = NP'($urandom);
         i_pu_rdy = ~(NP'(1) << $urandom_range(0, NP - 1));
      end
   endtask

   task automatic scramble();
      i_except_pc    = $urandom;
      i_except_cause = 4'($urandom);
      i_irq_pc       = $urandom;
      i_mispred_pc   = $urandom;
      i_mtvec        = $urandom;
   endtask

   task automatic seq(input bit ex, input bit irq, input bit mp,
                      input int busy, input int fwait, input bit pulse,
                      input logic [31:0] epc, input logic [3:0] cause,
                      input logic [31:0] ipc, input logic [31:0] mpc,
                      input logic [31:0] mtv);
      logic [31:0] tgt, mepc, mcause;
      bit trap, tmo;
      int nd;
      mepc = '0;
      mcause = '0;
      if (ex) begin
         tgt = {mtv[31:2], 2'b00}; mepc = epc;
         mcause = {28'b0, cause}; trap = 1'b1;
      end else if (irq) begin
         tgt = {mtv[31:2], 2'b00}; mepc = ipc;
         mcause = 32'h8000_000B; trap = 1'b1;
      end else begin
         tgt = mpc; trap = 1'b0;
      end
      tmo = (busy >= TO);
      nd = tmo ? TO : busy + 1;
      chk("idle_stall", o_stall, 0);
      chk("idle_vld", o_redirect_vld, 0);
      chk("idle_err", o_drain_err, 32'(err_exp));
      i_except_vld = ex; i_irq = irq; i_mispred_vld = mp;
      i_except_pc = epc; i_except_cause = cause; i_irq_pc = ipc;
      i_mispred_pc = mpc; i_mtvec = mtv;
      i_fetch_rdy = 1'($urandom);
      set_pu(1'($urandom));
      @(negedge clk);
      chk("flush", o_flush, 1);
      chk("flush_stall", o_stall, 1);
      chk("flush_vld", o_redirect_vld, 0);
      chk("flush_csr", o_csr_we, 0);
      i_except_vld = 1'b0; i_mispred_vld = 1'b0;
      scramble();
      @(negedge clk);
      for (int i = 0; i < nd; i++) begin
         chk("drain_stall", o_stall, 1);
         chk("drain_flush", o_flush, 0);
         chk("drain_vld", o_redirect_vld, 0);
         chk("drain_csr", o_csr_we, 0);
         set_pu(i < busy);
         i_except_vld = pulse && (i == 0);
         i_mispred_vld = pulse && (i == 0);
         scramble();
         @(negedge clk);
      end
      if (tmo) err_exp = 1'b1;
      for (int j = 0; j <= fwait; j++) begin
         chk("redir_vld", o_redirect_vld, 1);
         chk("redir_pc", o_redirect_pc, tgt);
         chk("redir_stall", o_stall, 1);
         chk("redir_flush", o_flush, 0);
         chk("redir_csr", o_csr_we, 32'((j == 0) && trap));
         if (j == 0 && trap) begin
            chk("mepc", o_mepc, mepc);
            chk("mcause", o_mcause, mcause);
         end
         chk("redir_err", o_drain_err, 32'(err_exp));
         i_fetch_rdy = (j == fwait);
         i_except_vld = 1'($urandom);
         i_mispred_vld = 1'($urandom);
         set_pu(1'($urandom));
         scramble();
         @(negedge clk);
      end
      i_except_vld = 1'b0; i_mispred_vld = 1'b0;
   endtask

   initial begin
      bit ex, irq, mp;
      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_stall", o_stall, 0);
      chk("rst_flush", o_flush, 0);
      chk("rst_vld", o_redirect_vld, 0);
      chk("rst_pc", o_redirect_pc, 0);
      chk("rst_csr", o_csr_we, 0);
      chk("rst_mepc", o_mepc, 0);
      chk("rst_mcause", o_mcause, 0);
      chk("rst_err", o_drain_err, 0);
      rst = 1'b0;
      @(negedge clk);
      seq(1, 0, 0, 0, 0, 0, 32'h100, 4'd2, 32'h0, 32'h0, 32'h8000_0004);
      seq(1, 1, 1, 2, 1, 0, 32'h440, 4'd5, 32'h990, 32'h1234, 32'h7000_0003);
      seq(0, 1, 0, 0, 0, 0, 32'h0, 4'd0, 32'h994, 32'h5678, 32'h7000_0103);
      i_irq = 1'b0;
      seq(0, 0, 1, 5, 3, 0, 32'h0, 4'd0, 32'h0, 32'h2040, 32'h0);
      seq(0, 0, 1, 7, 0, 0, 32'h0, 4'd0, 32'h0, 32'h3000, 32'h0);
      chk("no_err_at_T-1", o_drain_err, 0);
      seq(0, 0, 1, 20, 0, 0, 32'h0, 4'd0, 32'h0, 32'h4000, 32'h0);
      seq(1, 0, 0, 8, 1, 0, 32'h500, 4'd7, 32'h0, 32'h0, 32'h100);
      seq(1, 0, 0, 3, 1, 1, 32'h600, 4'd3, 32'h0, 32'h0, 32'h204);
      for (int k = 0; k < 40; k++) begin
         ex = 1'($urandom); irq = 1'($urandom); mp = 1'($urandom);
         if (!(ex | irq | mp)) mp = 1'b1;
         seq(ex, irq, mp, $urandom_range(0, 10), $urandom_range(0, 3),
             1'($urandom), $urandom, 4'($urandom), $urandom,
             $urandom, $urandom);
         i_irq = 1'b0;
      end
      i_except_vld = 1'b1; i_except_pc = 32'h700;
      i_except_cause = 4'd1; i_mtvec = 32'h900;
      set_pu(0); i_fetch_rdy = 1'b0;
      @(negedge clk);
      i_except_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_vld", o_redirect_vld, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", o_stall, 0);
      chk("mid_rst_vld", o_redirect_vld, 0);
      chk("mid_rst_pc", o_redirect_pc, 0);
      chk("mid_rst_csr", o_csr_we, 0);
      chk("mid_rst_mepc", o_mepc, 0);
      chk("mid_rst_mcause", o_mcause, 0);
      chk("mid_rst_err", o_drain_err, 0);
      err_exp = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", o_stall, 0);
      seq(0, 0, 1, 1, 1, 0, 32'h0, 4'd0, 32'h0, 32'h8888, 32'h0);
      i_irq = 1'b0;
      @(negedge clk);
      chk("end_stall", o_stall, 0);
      chk("end_vld", o_redirect_vld, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/rv32i_redirect_ctrl.md
# rv32i_redirect_ctrl

Front-end redirect sequencer for the RV32I core. It arbitrates among three redirect sources: ROB exception, external interrupt and ROB branch mispredict. For the winning source it flushes the pipeline, waits for all processing units (PUs) to drain, and writes trap CSRs when the source is a trap. It then hands the fetch stage a new PC under a valid/ready handshake. It sits between the ROB, the PU array, the CSR file and fetch, and stalls dispatch for the whole sequence.

## Interface
Parameters:
- NUM_PUS, 4, number of processing units monitored for drain
- DRAIN_TIMEOUT, 255, max DRAIN cycles before forced exit; range 1..255, 8-bit counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- i_except_vld  in  1  ROB exception at commit, single-cycle pulse
- i_except_pc  in  32  PC of the excepting instruction
- i_except_cause  in  4  exception code
- i_irq  in  1  external interrupt, level; held until serviced
- i_irq_pc  in  32  PC of the next instruction to commit
- i_mispred_vld  in  1  ROB branch mispredict, single-cycle pulse
- i_mispred_pc  in  32  correct branch target
- i_mtvec  in  32  trap vector base
- i_pu_vld  in  NUM_PUS  PU output valid
- i_pu_rdy  in  NUM_PUS  PU input ready
- i_fetch_rdy  in  1  fetch accepts redirect
- o_stall  out  1  hold dispatch
- o_flush  out  1  pipeline flush pulse
- o_csr_we  out  1  write mepc/mcause, one cycle
- o_mepc  out  32  mepc write data
- o_mcause  out  32  mcause write data
- o_redirect_vld  out  1  redirect request to fetch
- o_redirect_pc  out  32  new fetch PC
- o_drain_err  out  1  sticky drain timeout flag

## Operation
- States: IDLE, FLUSH, DRAIN, REDIRECT.
- IDLE: sample requests every cycle with priority except > irq > mispred. The winner is captured into internal registers:
  - Redirect target: trap sources get {i_mtvec[31:2],2'b00}; mispred gets i_mispred_pc.
  - mepc: i_except_pc or i_irq_pc.
  - mcause: except gets {28'b0,i_except_cause}; irq gets {1'b1,27'b0,4'd11}.
  - Trap flag: set for except and irq.
- After capture, go to FLUSH.
- Losing requests in the same cycle are dropped. i_except_vld and i_mispred_vld pulses arriving outside IDLE are dropped, because they belong to flushed instructions. i_irq is level and is re-sampled on return to IDLE.
- FLUSH: o_flush=1 for exactly one cycle. Clear the drain counter. Go to DRAIN.
- DRAIN: pipeline is flushed when ~|i_pu_vld & &i_pu_rdy.
  - If flushed, go to REDIRECT.
  - Otherwise increment the counter. When the counter reaches DRAIN_TIMEOUT, set o_drain_err and go to REDIRECT.
- REDIRECT:
  - o_redirect_vld=1 with o_redirect_pc stable until i_fetch_rdy.
  - o_csr_we=1 only in the first REDIRECT cycle, and only if the trap flag is set. o_mepc/o_mcause hold the captured values.
  - On the o_redirect_vld & i_fetch_rdy cycle, go to IDLE.
- o_stall = (state != IDLE).
- o_drain_err is cleared only by rst.

## Timing
- All outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.
- Reset values: state IDLE; o_stall, o_flush, o_csr_we, o_redirect_vld, o_drain_err = 0; o_redirect_pc, o_mepc, o_mcause = 0; counter 0.
- Request sampled at cycle N:
  - N+1: FLUSH, o_stall=1, o_flush=1.
  - N+2: DRAIN.
  - N+3 at the earliest: REDIRECT.
- Minimum request-to-o_redirect_vld latency is 3 cycles.
- Handshake completes at cycle M. At M+1 the block is in IDLE with o_stall=0, and a new request may be sampled at M+1.
- Back-to-back: a request present at M+1 starts a new sequence with no dead cycle.
- A timeout with DRAIN_TIMEOUT=T leaves DRAIN after T non-flushed DRAIN cycles.
- rst asserted mid-sequence immediately returns the block to the reset values. Any pending redirect and CSR write are abandoned.

## Test plan
- Exception, PUs already idle: i_except_vld with pc=0x100, cause=2, mtvec=0x8000_0004, fetch_rdy=1 at N. Expect o_flush at N+1, o_csr_we at N+3 with mepc=0x100 and mcause=0x2, redirect_pc=0x8000_0004 at N+3, o_stall low at N+4.
- Simultaneous requests: i_except_vld, i_irq and i_mispred_vld together. Expect the exception to win. After return to IDLE with i_irq still high, expect a second sequence with mcause=0x8000_000B and redirect_pc=mtvec.
- Mispredict with slow drain and slow fetch: i_mispred_pc=0x2040, i_pu_vld nonzero for 5 DRAIN cycles, i_fetch_rdy low for 3 cycles. Expect o_csr_we never asserted, and o_redirect_vld held at 0x2040 for 4 cycles.
- Drain timeout: DRAIN_TIMEOUT=8 with a PU stuck not ready. Expect REDIRECT after 8 DRAIN cycles and o_drain_err=1 sticky through later sequences.
- Dropped pulses: i_except_vld and i_mispred_vld pulsed during DRAIN. Expect no effect on the current target and no extra sequence.
- Reset mid-REDIRECT: assert rst while o_redirect_vld=1. Expect all outputs 0 immediately and IDLE after release.
